// File: rtl/bpred_update_sched.sv
// ---------------------------------------------------------------------------
// bpred_update_sched
//
// Buffers resolved-branch updates coming from execute in a small in-order
// FIFO and issues them, at most one per cycle, to the next-PC predictor's
// update port. Also sequences a full predictor flush:
//   IDLE -> DRAIN (empty the FIFO) -> WALK (invalidate pulse, then clear every
//   BHT/BTB index once) -> DONE (one-cycle completion pulse) -> IDLE.
// Fetch-side prediction is held off (pred_stall_o) for the whole flush.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   ex_valid_i / ex_ready_o       update handshake from execute
//   ex_source_i, ex_target_i      branch PC and resolved target
//   ex_taken_i, ex_not_taken_i    conditional outcome (taken wins if both set)
//   ex_is_call_i/ret_i/jmp_i      branch type
//   upd_hold_i                    predictor cannot accept updates this cycle
//   flush_req_i                   pulse: start a full predictor flush
//   branch_*                      head-of-queue update to the predictor
//   invalidate_o                  one-cycle predictor invalidate
//   clr_valid_o, clr_bht_idx_o    BHT clear port
//   clr_btb_valid_o, clr_btb_idx_o BTB clear port
//   pred_stall_o, flush_busy_o    flush in progress
//   flush_done_o                  one-cycle pulse when the flush completes
// ---------------------------------------------------------------------------
module bpred_update_sched #(
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_DEPTH_W      = 2,
  parameter int NUM_BHT_ENTRIES   = 512,
  parameter int NUM_BHT_ENTRIES_W = 9,
  parameter int NUM_BTB_ENTRIES   = 32,
  parameter int NUM_BTB_ENTRIES_W = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ex_valid_i,
  output logic                         ex_ready_o,
  input  logic [31:0]                  ex_source_i,
  input  logic [31:0]                  ex_target_i,
  input  logic                         ex_taken_i,
  input  logic                         ex_not_taken_i,
  input  logic                         ex_is_call_i,
  input  logic                         ex_is_ret_i,
  input  logic                         ex_is_jmp_i,
  input  logic                         upd_hold_i,
  input  logic                         flush_req_i,
  output logic                         branch_request_o,
  output logic [31:0]                  branch_source_o,
  output logic [31:0]                  branch_pc_o,
  output logic                         branch_is_taken_o,
  output logic                         branch_is_not_taken_o,
  output logic                         branch_is_call_o,
  output logic                         branch_is_ret_o,
  output logic                         branch_is_jmp_o,
  output logic                         invalidate_o,
  output logic                         clr_valid_o,
  output logic [NUM_BHT_ENTRIES_W-1:0] clr_bht_idx_o,
  output logic                         clr_btb_valid_o,
  output logic [NUM_BTB_ENTRIES_W-1:0] clr_btb_idx_o,
  output logic                         pred_stall_o,
  output logic                         flush_busy_o,
  output logic                         flush_done_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] WALK  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [FIFO_DEPTH_W:0]        FULL_CNT = (FIFO_DEPTH_W+1)'(FIFO_DEPTH);
  localparam logic [NUM_BHT_ENTRIES_W-1:0] LAST_IDX = NUM_BHT_ENTRIES_W'(NUM_BHT_ENTRIES - 1);
  // One extra bit so the compare still works when the BTB is as large as the BHT.
  localparam logic [NUM_BHT_ENTRIES_W:0]   BTB_LIM  = (NUM_BHT_ENTRIES_W+1)'(NUM_BTB_ENTRIES);

  logic [1:0]                   state;
  logic [FIFO_DEPTH_W-1:0]      wr_ptr;
  logic [FIFO_DEPTH_W-1:0]      rd_ptr;
  logic [FIFO_DEPTH_W:0]        count;
  logic [NUM_BHT_ENTRIES_W-1:0] idx;

  // Entry payload; not reset, only the pointers/count qualify it.
  logic [31:0] src_mem   [FIFO_DEPTH];
  logic [31:0] tgt_mem   [FIFO_DEPTH];
  logic [4:0]  flags_mem [FIFO_DEPTH];   // {taken, not_taken, call, ret, jmp}

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic walking;
  logic [4:0] head_flags;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign walking = (state == WALK);

  assign ex_ready_o       = ~full & (state == IDLE);
  assign push             = ex_valid_i & ex_ready_o;
  assign branch_request_o = ~empty & ~upd_hold_i & ((state == IDLE) | (state == DRAIN));
  assign pop              = branch_request_o;

  // Head fields are forced to zero while the queue is empty so the update
  // port never shows stale payload (and is all-zero out of reset).
  assign head_flags            = empty ? 5'd0 : flags_mem[rd_ptr];
  assign branch_source_o       = empty ? 32'd0 : src_mem[rd_ptr];
  assign branch_pc_o           = empty ? 32'd0 : tgt_mem[rd_ptr];
  assign branch_is_taken_o     = head_flags[4];
  assign branch_is_not_taken_o = head_flags[3];
  assign branch_is_call_o      = head_flags[2];
  assign branch_is_ret_o       = head_flags[1];
  assign branch_is_jmp_o       = head_flags[0];

  // The walk counter is still 0 only on the first WALK cycle.
  assign invalidate_o    = walking & (idx == '0);
  assign clr_valid_o     = walking;
  assign clr_bht_idx_o   = walking ? idx : '0;
  assign clr_btb_valid_o = walking & ({1'b0, idx} < BTB_LIM);
  assign clr_btb_idx_o   = clr_btb_valid_o ? idx[NUM_BTB_ENTRIES_W-1:0] : '0;

  assign flush_busy_o = (state != IDLE);
  assign pred_stall_o = flush_busy_o;
  assign flush_done_o = (state == DONE);

  // Payload storage
  always_ff @(posedge clk_i) begin
    if (push) begin
      src_mem[wr_ptr]   <= ex_source_i;
      tgt_mem[wr_ptr]   <= ex_target_i;
      // A branch flagged both ways is recorded as taken.
      flags_mem[wr_ptr] <= {ex_taken_i, ex_not_taken_i & ~ex_taken_i,
                            ex_is_call_i, ex_is_ret_i, ex_is_jmp_i};
    end
  end

  // Queue control, flush sequencer and walk counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (flush_req_i) state <= DRAIN;
        end
        DRAIN: begin
          // Intake is closed here, so once empty the queue stays empty.
          if (empty) state <= WALK;
        end
        WALK: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpred_update_sched.sv
module tb_bpred_update_sched;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] ex_source_i = '0;
  logic [31:0] ex_target_i = '0;
  logic        ex_taken_i = 1'b0;
  logic        ex_not_taken_i = 1'b0;
  logic        ex_is_call_i = 1'b0;
  logic        ex_is_ret_i = 1'b0;
  logic        ex_is_jmp_i = 1'b0;
  logic        upd_hold_i = 1'b0;
  logic        flush_req_i = 1'b0;
  logic        branch_request_o;
  logic [31:0] branch_source_o;
  logic [31:0] branch_pc_o;
  logic        branch_is_taken_o;
  logic        branch_is_not_taken_o;
  logic        branch_is_call_o;
  logic        branch_is_ret_o;
  logic        branch_is_jmp_o;
  logic        invalidate_o;
  logic        clr_valid_o;
  logic [8:0]  clr_bht_idx_o;
  logic        clr_btb_valid_o;
  logic [4:0]  clr_btb_idx_o;
  logic        pred_stall_o;
  logic        flush_busy_o;
  logic        flush_done_o;

  always #5 clk = ~clk;

  bpred_update_sched dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_source_i(ex_source_i), .ex_target_i(ex_target_i),
    .ex_taken_i(ex_taken_i), .ex_not_taken_i(ex_not_taken_i),
    .ex_is_call_i(ex_is_call_i), .ex_is_ret_i(ex_is_ret_i), .ex_is_jmp_i(ex_is_jmp_i),
    .upd_hold_i(upd_hold_i), .flush_req_i(flush_req_i),
    .branch_request_o(branch_request_o), .branch_source_o(branch_source_o),
    .branch_pc_o(branch_pc_o), .branch_is_taken_o(branch_is_taken_o),
    .branch_is_not_taken_o(branch_is_not_taken_o), .branch_is_call_o(branch_is_call_o),
    .branch_is_ret_o(branch_is_ret_o), .branch_is_jmp_o(branch_is_jmp_o),
    .invalidate_o(invalidate_o), .clr_valid_o(clr_valid_o), .clr_bht_idx_o(clr_bht_idx_o),
    .clr_btb_valid_o(clr_btb_valid_o), .clr_btb_idx_o(clr_btb_idx_o),
    .pred_stall_o(pred_stall_o), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o)
  );

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] tgt;
    logic        tk, nt, call, ret, jmp;
  } ent_t;

  // Reference model: pending updates plus a description of where the flush is.
  ent_t q[$];
  bit   in_flush = 1'b0;   // flush requested and not yet finished walking
  int   walk_i   = -1;     // -1 while emptying the queue, else index being cleared
  bit   done_now = 1'b0;   // completion cycle

  int checks = 0;
  int errors = 0;
  int n_clr, n_btb, n_inval, n_done;
  logic [31:0] issued[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_flush = 1'b0;
    walk_i   = -1;
    done_now = 1'b0;
  endtask

  task automatic clear_tallies();
    n_clr = 0; n_btb = 0; n_inval = 0; n_done = 0;
    issued.delete();
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return
  // just after the rising edge so the caller can set up the next inputs.
  task automatic step();
    bit busy, walking, rdy, req;
    int pre;
    ent_t e;
    @(negedge clk);
    busy    = in_flush | done_now;
    walking = in_flush && (walk_i >= 0);
    rdy     = !busy && (q.size() < 4);
    req     = (q.size() > 0) && !upd_hold_i && !walking && !done_now;

    chk("ex_ready", 32'(ex_ready_o), 32'(rdy));
    chk("branch_request", 32'(branch_request_o), 32'(req));
    if (req) begin
      chk("branch_source", branch_source_o, q[0].src);
      chk("branch_pc", branch_pc_o, q[0].tgt);
      chk("branch_flags",
          32'({branch_is_taken_o, branch_is_not_taken_o, branch_is_call_o,
               branch_is_ret_o, branch_is_jmp_o}),
          32'({q[0].tk, q[0].nt, q[0].call, q[0].ret, q[0].jmp}));
    end
    chk("invalidate", 32'(invalidate_o), 32'(walking && walk_i == 0));
    chk("clr_valid", 32'(clr_valid_o), 32'(walking));
    if (walking) begin
      chk("clr_bht_idx", 32'(clr_bht_idx_o), 32'(walk_i));
      chk("clr_btb_valid", 32'(clr_btb_valid_o), 32'(walk_i < 32));
      if (walk_i < 32) chk("clr_btb_idx", 32'(clr_btb_idx_o), 32'(walk_i % 32));
    end else begin
      chk("clr_btb_valid", 32'(clr_btb_valid_o), 32'd0);
    end
    chk("flush_busy", 32'(flush_busy_o), 32'(busy));
    chk("pred_stall", 32'(pred_stall_o), 32'(busy));
    chk("flush_done", 32'(flush_done_o), 32'(done_now));

    n_clr   += int'(clr_valid_o);
    n_btb   += int'(clr_btb_valid_o);
    n_inval += int'(invalidate_o);
    n_done  += int'(flush_done_o);
    if (branch_request_o) issued.push_back(branch_source_o);

    pre = q.size();
    if (req) void'(q.pop_front());
    if (ex_valid_i && rdy) begin
      e.src = ex_source_i; e.tgt = ex_target_i;
      e.tk = ex_taken_i; e.nt = ex_not_taken_i & ~ex_taken_i;
      e.call = ex_is_call_i; e.ret = ex_is_ret_i; e.jmp = ex_is_jmp_i;
      q.push_back(e);
    end
    if (done_now) begin
      done_now = 1'b0;
    end else if (in_flush) begin
      if (walk_i < 0) begin
        if (pre == 0) walk_i = 0;
      end else if (walk_i == 511) begin
        in_flush = 1'b0; done_now = 1'b1; walk_i = -1;
      end else begin
        walk_i++;
      end
    end else if (flush_req_i) begin
      in_flush = 1'b1; walk_i = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] s, input logic [31:0] t, input logic tk, input logic nt);
    ex_valid_i = 1'b1; ex_source_i = s; ex_target_i = t;
    ex_taken_i = tk; ex_not_taken_i = nt;
    ex_is_call_i = 1'b0; ex_is_ret_i = 1'b0; ex_is_jmp_i = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_tallies();

    // Reset state
    #3;
    chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_outputs",
        32'({branch_request_o, invalidate_o, clr_valid_o, clr_btb_valid_o,
             pred_stall_o, flush_busy_o, flush_done_o}), 32'd0);
    chk("rst_branch_source", branch_source_o, 32'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;
    chk("post_rst_empty", 32'(branch_request_o), 32'd0);

    // Single update, one-cycle latency
    offer(32'h100, 32'h200, 1'b1, 1'b0);
    step();
    ex_valid_i = 1'b0;
    #1;
    chk("lat_request", 32'(branch_request_o), 32'd1);
    chk("lat_source", branch_source_o, 32'h100);
    chk("lat_target", branch_pc_o, 32'h200);
    chk("lat_taken", 32'(branch_is_taken_o), 32'd1);
    step();
    chk("lat_gone", 32'(branch_request_o), 32'd0);

    // Fill under hold, then drain back-to-back
    upd_hold_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(32'(i * 16), 32'(i * 16 + 1), 1'b0, 1'b1);
      step();
    end
    ex_valid_i = 1'b0;
    #1;
    chk("full_not_ready", 32'(ex_ready_o), 32'd0);
    upd_hold_i = 1'b0;
    clear_tallies();
    for (int i = 0; i < 5; i++) step();
    chk("drain_count", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("drain_order", issued[i], 32'((i + 1) * 16));

    // Flush with two queued updates
    upd_hold_i = 1'b1;
    offer(32'hA0, 32'hB0, 1'b1, 1'b0); step();
    offer(32'hA4, 32'hB4, 1'b0, 1'b1); step();
    ex_valid_i = 1'b0;
    upd_hold_i = 1'b0;
    clear_tallies();
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    #1;
    chk("flush_stall", 32'(pred_stall_o), 32'd1);
    for (int i = 0; i < 600 && n_done == 0; i++) step();
    #1;
    chk("flush_ready_after", 32'(ex_ready_o), 32'd1);
    chk("flush_drained", 32'(issued.size()), 32'd2);
    chk("flush_inval_cycles", 32'(n_inval), 32'd1);
    chk("flush_clr_cycles", 32'(n_clr), 32'd512);
    chk("flush_btb_cycles", 32'(n_btb), 32'd32);
    chk("flush_done_pulses", 32'(n_done), 32'd1);

    // Asynchronous reset in the middle of the walk
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i < 200 && !(clr_valid_o && clr_bht_idx_o == 9'd100); i++) step();
    chk("walk_reached_100", 32'(clr_bht_idx_o), 32'd100);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_outputs",
        32'({branch_request_o, invalidate_o, clr_valid_o, clr_btb_valid_o,
             pred_stall_o, flush_busy_o, flush_done_o}), 32'd0);
    chk("midrst_ready", 32'(ex_ready_o), 32'd1);
    model_reset();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    clear_tallies();
    for (int i = 0; i < 20; i++) step();
    chk("midrst_no_walk", 32'(n_clr), 32'd0);

    // Both outcome flags set, and a second request during the walk
    offer(32'h55, 32'h66, 1'b1, 1'b1);
    step();
    ex_valid_i = 1'b0;
    #1;
    chk("both_taken", 32'(branch_is_taken_o), 32'd1);
    chk("both_not_taken", 32'(branch_is_not_taken_o), 32'd0);
    step();
    clear_tallies();
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i < 50; i++) step();
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i < 1200; i++) step();
    chk("ignored_req_done", 32'(n_done), 32'd1);

    // Randomized traffic with occasional holds and flushes
    for (int i = 0; i < 4000; i++) begin
      ex_valid_i     = 1'($urandom_range(0, 1));
      ex_source_i    = $urandom;
      ex_target_i    = $urandom;
      ex_taken_i     = 1'($urandom_range(0, 1));
      ex_not_taken_i = 1'($urandom_range(0, 1));
      ex_is_call_i   = 1'($urandom_range(0, 1));
      ex_is_ret_i    = 1'($urandom_range(0, 1));
      ex_is_jmp_i    = 1'($urandom_range(0, 1));
      upd_hold_i     = ($urandom_range(0, 4) == 0);
      flush_req_i    = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
